// File: rtl/if_id_stage.sv
// IF stage plus IF/ID pipeline register for a 5-stage RV32 core.
// Handles the program counter, the load-use stall, the EX redirect flush, and the stall/flush counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        id_ex_MemRead,
    input  logic [4:0]  id_ex_rd,
    output logic [31:0] pc_out,
    output logic [31:0] if_id_PC_out,
    output logic [31:0] if_id_instr_out,
    output logic        if_id_valid_out,
    output logic        id_ex_flush,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [31:0] pc_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;
    logic        if_valid_q;
    logic [31:0] stall_q;
    logic [31:0] flush_q;
    logic        rs1_match;
    logic        rs2_match;
    logic        hazard;

    // Both source fields are compared whatever the opcode; a false stall costs only a cycle.
    assign rs1_match = (id_ex_rd == if_instr_q[19:15]);
    assign rs2_match = (id_ex_rd == if_instr_q[24:20]);
    assign hazard    = id_ex_MemRead && (id_ex_rd != 5'd0) && if_valid_q && (rs1_match || rs2_match);

    assign id_ex_flush = hazard || branch_taken;
    assign imem_addr   = pc_q;

    // A redirect takes priority over a stall: the younger instruction in ID is squashed anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            if_pc_q    <= 32'd0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
            stall_q    <= 32'd0;
            flush_q    <= 32'd0;
        end else if (branch_taken) begin
            pc_q       <= {branch_target[31:2], 2'b00};
            if_pc_q    <= 32'd0;
            if_instr_q <= NOP_INSTR;
            if_valid_q <= 1'b0;
            flush_q    <= flush_q + 32'd1;
        end else if (hazard) begin
            stall_q    <= stall_q + 32'd1;
        end else begin
            pc_q       <= pc_q + 32'd4;
            if_pc_q    <= pc_q;
            if_instr_q <= imem_rdata;
            if_valid_q <= 1'b1;
        end
    end

    assign pc_out          = pc_q;
    assign if_id_PC_out    = if_pc_q;
    assign if_id_instr_out = if_instr_q;
    assign if_id_valid_out = if_valid_q;
    assign stall_cnt       = stall_q;
    assign flush_cnt       = flush_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model of the fetch stage.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD_X3_X1_X2 = 32'h0020_81B3;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ex_MemRead;
    logic [4:0]  id_ex_rd;
    logic [31:0] pc_out;
    logic [31:0] if_id_PC_out;
    logic [31:0] if_id_instr_out;
    logic        if_id_valid_out;
    logic        id_ex_flush;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    // Instruction memory: 64 words, indexed by word address, aliased over the whole space.
    logic [31:0] mem [64];
    assign imem_rdata = mem[imem_addr[7:2]];

    // Reference model state
    logic [31:0] m_pc, m_ipc, m_ins, m_stall, m_flush;
    logic        m_v;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_stage dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .id_ex_MemRead(id_ex_MemRead), .id_ex_rd(id_ex_rd),
        .pc_out(pc_out), .if_id_PC_out(if_id_PC_out),
        .if_id_instr_out(if_id_instr_out), .if_id_valid_out(if_id_valid_out),
        .id_ex_flush(id_ex_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_ipc = 32'd0; m_ins = NOP; m_v = 1'b0;
        m_stall = 32'd0; m_flush = 32'd0;
    endtask

    task automatic check_state();
        check("pc_out", pc_out, m_pc);
        check("if_id_PC_out", if_id_PC_out, m_ipc);
        check("if_id_instr_out", if_id_instr_out, m_ins);
        check("if_id_valid_out", {31'd0, if_id_valid_out}, {31'd0, m_v});
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic fill_mem(input logic [31:0] word);
        for (int i = 0; i < 64; i++) mem[i] = word;
    endtask

    // Entered and left on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        branch_taken = 1'b0; branch_target = 32'd0; id_ex_MemRead = 1'b0; id_ex_rd = 5'd0;
        rst = 1'b1;
        model_reset();
        #1;
        check_state();
        check("reset_flush", {31'd0, id_ex_flush}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance model, check registers.
    task automatic step(input logic br, input logic [31:0] tgt, input logic mr, input logic [4:0] rd);
        logic hz;
        branch_taken = br; branch_target = tgt; id_ex_MemRead = mr; id_ex_rd = rd;
        hz = mr && (rd != 5'd0) && m_v && (rd == m_ins[19:15] || rd == m_ins[24:20]);
        #1;
        check("imem_addr", imem_addr, m_pc);
        check("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, hz | br});
        @(posedge clk);
        if (br) begin
            m_pc = tgt & 32'hFFFF_FFFC; m_ipc = 32'd0; m_ins = NOP; m_v = 1'b0;
            m_flush = m_flush + 32'd1;
        end else if (hz) begin
            m_stall = m_stall + 32'd1;
        end else begin
            m_ipc = m_pc; m_ins = mem[m_pc[7:2]]; m_v = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
        check_state();
    endtask

    initial begin
        rst = 1'b1;
        branch_taken = 1'b0; branch_target = 32'd0; id_ex_MemRead = 1'b0; id_ex_rd = 5'd0;
        fill_mem(NOP);
        model_reset();

        // Free run from reset
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, 5'd0);
        check("free_pc", pc_out, 32'h10);
        check("free_if_pc", if_id_PC_out, 32'hC);
        check("free_valid", {31'd0, if_id_valid_out}, 32'd1);

        // Load-use stall, then the same pattern with rd=0
        mem[4] = ADD_X3_X1_X2;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, 5'd0);
        check("lu_instr", if_id_instr_out, ADD_X3_X1_X2);
        step(1'b0, 32'd0, 1'b1, 5'd2);
        check("lu_pc_held", pc_out, 32'h14);
        check("lu_stall_cnt", stall_cnt, 32'd1);
        step(1'b0, 32'd0, 1'b1, 5'd2);
        step(1'b0, 32'd0, 1'b1, 5'd2);
        check("lu_keep_stall", stall_cnt, 32'd3);
        step(1'b0, 32'd0, 1'b1, 5'd0);
        check("lu_rd0_pc", pc_out, 32'h18);
        check("lu_rd0_stall", stall_cnt, 32'd3);

        // Redirect at pc=0x10
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b0, 5'd0);
        step(1'b1, 32'h0000_0102, 1'b0, 5'd0);
        check("br_pc", pc_out, 32'h100);
        check("br_valid", {31'd0, if_id_valid_out}, 32'd0);
        check("br_instr", if_id_instr_out, NOP);
        check("br_flush_cnt", flush_cnt, 32'd1);

        // Redirect together with a hazard
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, 5'd0);
        step(1'b1, 32'h0000_0200, 1'b1, 5'd2);
        check("brhz_pc", pc_out, 32'h200);
        check("brhz_stall", stall_cnt, 32'd0);
        check("brhz_flush", flush_cnt, 32'd1);

        // Asynchronous reset pulse during a stall
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, 5'd0);
        branch_taken = 1'b0; id_ex_MemRead = 1'b1; id_ex_rd = 5'd2;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_state();
        #1 rst = 1'b0;
        @(negedge clk);
        step(1'b0, 32'd0, 1'b1, 5'd2);
        check("arst_fetch_pc", if_id_PC_out, 32'd0);
        check("arst_next_pc", pc_out, 32'd4);

        // Counter wrap and PC wrap
        fill_mem(NOP);
        mem[0] = ADD_X3_X1_X2;
        mem[63] = 32'h1234_5013;
        do_reset();
        step(1'b0, 32'd0, 1'b0, 5'd0);
        force dut.stall_q = 32'hFFFF_FFFF;
        #1 release dut.stall_q;
        m_stall = 32'hFFFF_FFFF;
        check("stall_preload", stall_cnt, 32'hFFFF_FFFF);
        step(1'b0, 32'd0, 1'b1, 5'd1);
        check("stall_wrap", stall_cnt, 32'd0);
        force dut.flush_q = 32'hFFFF_FFFF;
        #1 release dut.flush_q;
        m_flush = 32'hFFFF_FFFF;
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0);
        check("flush_wrap", flush_cnt, 32'd0);
        check("br_top_pc", pc_out, 32'hFFFF_FFFC);
        step(1'b0, 32'd0, 1'b0, 5'd0);
        check("pc_wrap", pc_out, 32'd0);
        check("pc_wrap_if_pc", if_id_PC_out, 32'hFFFF_FFFC);

        // Randomized traffic against the model
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = $urandom;
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            mem[i] = w;
        end
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) == 0), 32'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
